// File: rtl/bsg_link_sdr_reset_sequencer.sv
// Ordered reset/enable sequencer for one SDR link endpoint and its core node.
// Sequence: token-reset pulse, uplink, downlink, downstream, core reset release,
// then core enable. Every output is a registered level so downstream
// synchronizers never see a glitch.
module bsg_link_sdr_reset_sequencer #(
  parameter int phase_gap_cycles_p   = 64,
  parameter int token_pulse_cycles_p = 32,
  localparam int max_len_lp =
    (phase_gap_cycles_p > token_pulse_cycles_p) ? phase_gap_cycles_p : token_pulse_cycles_p,
  localparam int cnt_width_lp = $clog2(max_len_lp + 1)
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       restart_i,
  input  logic       hold_i,
  output logic       async_token_reset_o,
  output logic       async_uplink_reset_o,
  output logic       async_downlink_reset_o,
  output logic       async_downstream_reset_o,
  output logic       core_reset_o,
  output logic       core_en_o,
  output logic       done_o,
  output logic [2:0] stage_o
);

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StPre        = 3'd1,
    StToken      = 3'd2,
    StPost       = 3'd3,
    StUplink     = 3'd4,
    StDownlink   = 3'd5,
    StDownstream = 3'd6,
    StDone       = 3'd7
  } state_e;

  localparam logic [cnt_width_lp-1:0] GapLast   = cnt_width_lp'(phase_gap_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] TokenLast = cnt_width_lp'(token_pulse_cycles_p - 1);

  // Zero-length phases would collapse the ordering, so refuse them outright.
  if (phase_gap_cycles_p < 1) begin : g_bad_gap
    $fatal(1, "phase_gap_cycles_p must be >= 1");
  end
  if (token_pulse_cycles_p < 1) begin : g_bad_token
    $fatal(1, "token_pulse_cycles_p must be >= 1");
  end

  state_e                  state_q;
  logic [cnt_width_lp-1:0] cnt_q;
  logic                    core_wait_q;  // second pass of StDownstream (core reset released)
  logic                    token_q, uplink_q, downlink_q, downstream_q;
  logic                    core_reset_q, core_en_q, done_q;
  logic [cnt_width_lp-1:0] phase_last;
  logic                    phase_end;

  // Length of the current timed phase; only StToken uses the pulse width.
  always_comb begin
    phase_last = (state_q == StToken) ? TokenLast : GapLast;
    phase_end  = (cnt_q == phase_last);
  end

  // Sequencer state, phase counter and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      core_wait_q  <= 1'b0;
      token_q      <= 1'b0;
      uplink_q     <= 1'b1;
      downlink_q   <= 1'b1;
      downstream_q <= 1'b1;
      core_reset_q <= 1'b1;
      core_en_q    <= 1'b0;
      done_q       <= 1'b0;
    end else if (restart_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      core_wait_q  <= 1'b0;
      token_q      <= 1'b0;
      uplink_q     <= 1'b1;
      downlink_q   <= 1'b1;
      downstream_q <= 1'b1;
      core_reset_q <= 1'b1;
      core_en_q    <= 1'b0;
      done_q       <= 1'b0;
    end else if (!hold_i) begin
      if (state_q == StIdle) begin
        if (start_i) begin
          state_q <= StPre;
          cnt_q   <= '0;
        end
      end else if (state_q != StDone) begin
        if (!phase_end) begin
          cnt_q <= cnt_q + cnt_width_lp'(1);
        end else begin
          cnt_q <= '0;
          unique case (state_q)
            StPre: begin
              state_q <= StToken;
              token_q <= 1'b1;
            end
            StToken: begin
              state_q <= StPost;
              token_q <= 1'b0;
            end
            StPost: begin
              state_q  <= StUplink;
              uplink_q <= 1'b0;
            end
            StUplink: begin
              state_q    <= StDownlink;
              downlink_q <= 1'b0;
            end
            StDownlink: begin
              state_q      <= StDownstream;
              downstream_q <= 1'b0;
            end
            StDownstream: begin
              if (!core_wait_q) begin
                core_wait_q  <= 1'b1;
                core_reset_q <= 1'b0;
              end else begin
                state_q     <= StDone;
                core_wait_q <= 1'b0;
                core_en_q   <= 1'b1;
                done_q      <= 1'b1;
              end
            end
            StIdle, StDone: begin
            end
          endcase
        end
      end
    end
  end

  assign async_token_reset_o      = token_q;
  assign async_uplink_reset_o     = uplink_q;
  assign async_downlink_reset_o   = downlink_q;
  assign async_downstream_reset_o = downstream_q;
  assign core_reset_o             = core_reset_q;
  assign core_en_o                = core_en_q;
  assign done_o                   = done_q;
  assign stage_o                  = state_q;

endmodule

// File: tb/tb_bsg_link_sdr_reset_sequencer.sv
// Directed bench for the SDR link reset sequencer with G=4, T=2.
module tb_bsg_link_sdr_reset_sequencer;

  localparam int G = 4;
  localparam int T = 2;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic       restart_i = 1'b0;
  logic       hold_i = 1'b0;
  logic       token_o, uplink_o, downlink_o, downstream_o, core_reset_o, core_en_o, done_o;
  logic [2:0] stage_o;

  int n_checks = 0;
  int n_errors = 0;

  bsg_link_sdr_reset_sequencer #(
    .phase_gap_cycles_p  (G),
    .token_pulse_cycles_p(T)
  ) dut (
    .clk_i                   (clk),
    .reset_i                 (reset_i),
    .start_i                 (start_i),
    .restart_i               (restart_i),
    .hold_i                  (hold_i),
    .async_token_reset_o     (token_o),
    .async_uplink_reset_o    (uplink_o),
    .async_downlink_reset_o  (downlink_o),
    .async_downstream_reset_o(downstream_o),
    .core_reset_o            (core_reset_o),
    .core_en_o               (core_en_o),
    .done_o                  (done_o),
    .stage_o                 (stage_o)
  );

  always #5 clk = ~clk;

  // {token, uplink, downlink, downstream, core_reset, core_en, done, stage[2:0]}
  localparam logic [9:0] IdleVec = 10'b0_1111_00_000;

  logic [9:0] obs;
  assign obs = {token_o, uplink_o, downlink_o, downstream_o, core_reset_o, core_en_o, done_o,
                stage_o};

  task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Expected outputs e edges after the start edge; tl is the effective token
  // phase length (T, plus any hold cycles spent inside it).
  function automatic logic [9:0] exp_at(input int e, input int tl);
    logic tok, up, dn, ds, cr, en;
    logic [2:0] st;
    tok = (e >= G) && (e < G + tl);
    up  = !(e >= 2 * G + tl);
    dn  = !(e >= 3 * G + tl);
    ds  = !(e >= 4 * G + tl);
    cr  = !(e >= 5 * G + tl);
    en  = (e >= 6 * G + tl);
    if (e < G)               st = 3'd1;
    else if (e < G + tl)     st = 3'd2;
    else if (e < 2 * G + tl) st = 3'd3;
    else if (e < 3 * G + tl) st = 3'd4;
    else if (e < 4 * G + tl) st = 3'd5;
    else if (e < 6 * G + tl) st = 3'd6;
    else                     st = 3'd7;
    return {tok, up, dn, ds, cr, en, en, st};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    check_eq("reset", obs, IdleVec);
    reset_i = 1'b0;
    step();
    step();
    check_eq("idle_after_reset", obs, IdleVec);

    // Full sequence from a single start pulse
    start_i = 1'b1;
    for (int e = 0; e <= 28; e++) begin
      step();
      start_i = 1'b0;
      check_eq($sformatf("seq e=%0d", e), obs, exp_at(e, T));
    end

    // start_i in DONE is ignored
    start_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("done_ignore_start %0d", i), obs, exp_at(30, T));
    end

    // restart together with start: restart wins, stays in IDLE
    restart_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("restart_start_idle %0d", i), obs, IdleVec);
    end
    restart_i = 1'b0;
    start_i   = 1'b0;
    step();
    check_eq("idle_no_start", obs, IdleVec);

    // Restart mid-UPLINK; start held high relaunches after restart drops
    start_i = 1'b1;
    for (int e = 0; e <= 11; e++) begin
      step();
      if (e == 0) start_i = 1'b0;
    end
    check_eq("pre_restart e=11", obs, exp_at(11, T));
    restart_i = 1'b1;
    start_i   = 1'b1;
    step();  // edge 12
    check_eq("restart e=12", obs, IdleVec);
    step();  // edge 13
    check_eq("restart e=13", obs, IdleVec);
    restart_i = 1'b0;
    for (int e = 14; e <= 46; e++) begin
      step();
      check_eq($sformatf("relaunch e=%0d", e), obs, exp_at(e - 14, T));
    end
    start_i = 1'b0;

    // hold in IDLE blocks start
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    hold_i    = 1'b1;
    start_i   = 1'b1;
    step();
    step();
    check_eq("hold_blocks_start", obs, IdleVec);
    hold_i = 1'b0;

    // hold during TOKEN stretches the timeline by 3
    for (int e = 0; e <= 31; e++) begin
      hold_i = (e >= 5 && e <= 7);
      step();
      start_i = 1'b0;
      check_eq($sformatf("hold e=%0d", e), obs, exp_at(e, T + 3));
    end
    hold_i = 1'b0;

    // Asynchronous reset mid-DOWNLINK
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    start_i   = 1'b1;
    for (int e = 0; e <= 15; e++) begin
      step();
      start_i = 1'b0;
    end
    check_eq("pre_async e=15", obs, exp_at(15, T));
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    check_eq("async_reset_immediate", obs, IdleVec);
    @(negedge clk);
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("idle_after_async", obs, IdleVec);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check_eq("restart_after_async e=0", obs, exp_at(0, T));
    for (int e = 1; e <= G; e++) step();
    check_eq("restart_after_async e=4", obs, exp_at(G, T));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
